// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: state encoding, grant IDs and
// default widths.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_MAX_WAIT = 15;
  // Wide enough for the full MAX_WAIT range (1..255).
  localparam int unsigned WAIT_W       = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_XFER = 2'd1,
    DBG_XFER = 2'd2
  } state_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DBG = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker. Bit 0 is the CPU request and bit 1 is the debug
// request. On a tie, the port that was not granted last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  gnt_e       last_grant_i,
  output logic       gnt_valid_o,
  output gnt_e       grant_o
);

  // Pick a winner from the current requests.
  always_comb begin
    gnt_valid_o = |req_i;
    grant_o     = GNT_CPU;
    case (req_i)
      2'b01:   grant_o = GNT_CPU;
      2'b10:   grant_o = GNT_DBG;
      2'b11:   grant_o = (last_grant_i == GNT_CPU) ? GNT_DBG : GNT_CPU;
      default: grant_o = GNT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port and a debug/loader port onto one memory port. Only one
// access is outstanding at a time. Each access has a wait budget; when the
// budget runs out, the access completes with an error.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              dbg_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  // The last XFER cycle without mem_ready. A timeout fires here.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_e              state_q;
  gnt_e                last_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                mem_en_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                cpu_ack_q, cpu_err_q, dbg_ack_q, dbg_err_q;
  logic [DATA_W-1:0]   cpu_rdata_q, dbg_rdata_q;

  logic [1:0]          req_vec;
  logic                gnt_valid;
  gnt_e                gnt;

  // A request that is still high in its own ack cycle is stale.
  // Exclude it from arbitration.
  assign req_vec = {dbg_req & ~dbg_ack_q, cpu_req & ~cpu_ack_q};

  rr_arb2 u_rr (
    .req_i        (req_vec),
    .last_grant_i (last_q),
    .gnt_valid_o  (gnt_valid),
    .grant_o      (gnt)
  );

  // Arbitration, transfer tracking, wait counting, and completion/timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= GNT_DBG;
      wait_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      dbg_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      cpu_err_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      dbg_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            last_q   <= gnt;
            wait_q   <= '0;
            mem_en_q <= 1'b1;
            if (gnt == GNT_CPU) begin
              state_q     <= CPU_XFER;
              mem_we_q    <= cpu_we;
              mem_addr_q  <= cpu_addr;
              mem_wdata_q <= cpu_wdata;
            end else begin
              state_q     <= DBG_XFER;
              mem_we_q    <= dbg_we;
              mem_addr_q  <= dbg_addr;
              mem_wdata_q <= dbg_wdata;
            end
          end
        end
        CPU_XFER, DBG_XFER: begin
          if (mem_ready || (wait_q == WAIT_LAST)) begin
            // Completion takes priority over a timeout in the same cycle.
            state_q  <= IDLE;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (state_q == CPU_XFER) begin
              cpu_ack_q <= 1'b1;
              cpu_err_q <= ~mem_ready;
              if (!mem_ready)     cpu_rdata_q <= '0;
              else if (!mem_we_q) cpu_rdata_q <= mem_rdata;
            end else begin
              dbg_ack_q <= 1'b1;
              dbg_err_q <= ~mem_ready;
              if (!mem_ready)     dbg_rdata_q <= '0;
              else if (!mem_we_q) dbg_rdata_q <= mem_rdata;
            end
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_stall = cpu_req & ~cpu_ack_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_err   = cpu_err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_ack   = dbg_ack_q;
  assign dbg_err   = dbg_err_q;
  assign dbg_rdata = dbg_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, self-checking bench for mem_arbiter. Inputs change #1 after a
// rising edge and outputs are sampled at the same point.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, mem_ready;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
  logic        cpu_ack, cpu_err, cpu_stall, dbg_ack, dbg_err, mem_en, mem_we;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    #1;
    // Reset state
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk1("rst_cpu_ack", cpu_ack, 1'b0);
    chk1("rst_dbg_ack", dbg_ack, 1'b0);
    chk1("rst_cpu_err", cpu_err, 1'b0);
    chk1("rst_dbg_err", dbg_err, 1'b0);
    chk32("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk32("rst_dbg_rdata", dbg_rdata, 32'h0);
    step(); step();
    rst = 1'b1;
    step();

    // Minimum-latency CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040;
    #1 chk1("lat_stall_req", cpu_stall, 1'b1);
    step();
    chk1("lat_mem_en", mem_en, 1'b1);
    chk32("lat_mem_addr", mem_addr, 32'h0000_0040);
    chk1("lat_mem_we", mem_we, 1'b0);
    chk1("lat_no_ack_yet", cpu_ack, 1'b0);
    mem_ready = 1'b1; mem_rdata = 32'h8C01_0004;
    step();
    chk1("lat_cpu_ack", cpu_ack, 1'b1);
    chk1("lat_cpu_err", cpu_err, 1'b0);
    chk32("lat_cpu_rdata", cpu_rdata, 32'h8C01_0004);
    chk1("lat_mem_en_off", mem_en, 1'b0);
    chk1("lat_stall_off", cpu_stall, 1'b0);
    chk1("lat_dbg_ack", dbg_ack, 1'b0);
    cpu_req = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h1111_1111;
    step();
    chk1("lat_ack_pulse", cpu_ack, 1'b0);
    chk32("lat_rdata_hold", cpu_rdata, 32'h8C01_0004);

    // Reset before the tie test so last_grant is back at its reset value
    rst = 1'b0;
    #1;
    chk32("rst2_cpu_rdata", cpu_rdata, 32'h0);
    step();
    rst = 1'b1;
    step();

    // Round-robin with both requesters; each access takes one wait cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
    step();
    chk1("rr1_mem_en", mem_en, 1'b1);
    chk32("rr1_cpu_first", mem_addr, 32'h10);
    step();
    chk1("rr1_wait_en", mem_en, 1'b1);
    mem_ready = 1'b1; mem_rdata = 32'h0000_00A1;
    step();
    chk1("rr1_cpu_ack", cpu_ack, 1'b1);
    chk1("rr1_dbg_ack", dbg_ack, 1'b0);
    chk32("rr1_cpu_rdata", cpu_rdata, 32'h0000_00A1);
    mem_ready = 1'b0;
    step();
    chk1("rr2_mem_en", mem_en, 1'b1);
    chk32("rr2_dbg_second", mem_addr, 32'h20);
    chk1("rr2_cpu_ack_off", cpu_ack, 1'b0);
    step();
    mem_ready = 1'b1; mem_rdata = 32'h0000_00B2;
    step();
    chk1("rr2_dbg_ack", dbg_ack, 1'b1);
    chk1("rr2_cpu_ack", cpu_ack, 1'b0);
    chk32("rr2_dbg_rdata", dbg_rdata, 32'h0000_00B2);
    chk32("rr2_cpu_rdata_kept", cpu_rdata, 32'h0000_00A1);
    dbg_req = 1'b0; mem_ready = 1'b0;
    step();
    chk32("rr3_cpu_again", mem_addr, 32'h10);
    chk1("rr3_mem_en", mem_en, 1'b1);
    mem_ready = 1'b1; mem_rdata = 32'h0000_00C3;
    step();
    chk1("rr3_cpu_ack", cpu_ack, 1'b1);
    chk1("rr3_dbg_ack", dbg_ack, 1'b0);
    chk32("rr3_cpu_rdata", cpu_rdata, 32'h0000_00C3);
    mem_ready = 1'b0;

    // Debug write wins the tie (CPU was granted last). Ready arrives after 3 cycles.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h100; dbg_wdata = 32'hDEAD_BEEF;
    step();
    for (int i = 1; i <= 3; i++) begin
      chk1($sformatf("wr_mem_en_%0d", i), mem_en, 1'b1);
      chk1($sformatf("wr_mem_we_%0d", i), mem_we, 1'b1);
      chk32($sformatf("wr_mem_addr_%0d", i), mem_addr, 32'h100);
      chk32($sformatf("wr_mem_wdata_%0d", i), mem_wdata, 32'hDEAD_BEEF);
      chk1($sformatf("wr_stall_%0d", i), cpu_stall, 1'b1);
      chk1($sformatf("wr_no_ack_%0d", i), dbg_ack, 1'b0);
      if (i == 3) begin
        mem_ready = 1'b1;
        mem_rdata = 32'h5555_5555;
      end
      step();
    end
    chk1("wr_dbg_ack", dbg_ack, 1'b1);
    chk1("wr_dbg_err", dbg_err, 1'b0);
    chk32("wr_dbg_rdata_kept", dbg_rdata, 32'h0000_00B2);
    chk1("wr_mem_en_off", mem_en, 1'b0);
    chk1("wr_stall_after", cpu_stall, 1'b1);
    chk1("wr_cpu_ack", cpu_ack, 1'b0);
    dbg_req = 1'b0; dbg_we = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h7777_7777;

    // CPU read that times out: mem_ready never arrives
    step();
    chk32("to_addr", mem_addr, 32'h44);
    chk1("to_mem_we", mem_we, 1'b0);
    for (int i = 1; i < 15; i++) step();
    chk1("to_en_cycle15", mem_en, 1'b1);
    chk1("to_no_ack_cycle15", cpu_ack, 1'b0);
    step();
    chk1("to_cpu_ack", cpu_ack, 1'b1);
    chk1("to_cpu_err", cpu_err, 1'b1);
    chk32("to_cpu_rdata", cpu_rdata, 32'h0);
    chk1("to_mem_en_off", mem_en, 1'b0);
    cpu_req = 1'b0;
    step();
    chk1("to_ack_pulse", cpu_ack, 1'b0);
    chk1("to_err_pulse", cpu_err, 1'b0);

    // Ready arrives in the 15th wait cycle, so the access completes normally
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h48;
    step();
    for (int i = 1; i < 15; i++) step();
    chk1("edge_en_cycle15", mem_en, 1'b1);
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    chk1("edge_cpu_ack", cpu_ack, 1'b1);
    chk1("edge_cpu_err", cpu_err, 1'b0);
    chk32("edge_cpu_rdata", cpu_rdata, 32'h1234_5678);
    cpu_req = 1'b0; mem_ready = 1'b0;
    step();

    // Reset during DBG_XFER aborts the access
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h200;
    step();
    chk1("ab_mem_en", mem_en, 1'b1);
    step();
    rst = 1'b0;
    #1;
    chk1("ab_mem_en_async", mem_en, 1'b0);
    chk32("ab_mem_addr", mem_addr, 32'h0);
    chk1("ab_dbg_ack", dbg_ack, 1'b0);
    dbg_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h9999_0001;
    step();
    rst = 1'b1;
    step();
    chk1("ab_no_late_ack", dbg_ack, 1'b0);
    chk1("ab_idle_ready_ignored", cpu_ack, 1'b0);
    cpu_req = 1'b1; cpu_addr = 32'h60;
    dbg_req = 1'b1; dbg_addr = 32'h200;
    step();
    chk32("ab_tie_cpu", mem_addr, 32'h60);
    chk1("ab_tie_en", mem_en, 1'b1);
    chk1("ab_tie_no_ack", cpu_ack, 1'b0);
    step();
    chk1("ab_cpu_ack", cpu_ack, 1'b1);
    chk1("ab_dbg_ack2", dbg_ack, 1'b0);
    chk32("ab_cpu_rdata", cpu_rdata, 32'h9999_0001);
    cpu_req = 1'b0; dbg_req = 1'b0; mem_ready = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
